// File: rtl/button_event_encoder.sv
// Debounces two pushbuttons and a 4-bit DIP switch into six channels and queues edge events.
// Define EVENT_RELEASE_EN to queue release events as well as press events.
module button_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       sw1_i,
    input  logic       sw2_i,
    input  logic [3:0] sw3_i,
    output logic [7:0] evt_o,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [5:0] level_o,
    output logic       overflow_o
);
    localparam int NCH = 6;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [NCH-1:0] IDLE_RAW = 6'b000011;

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
        $error("DEBOUNCE_CYCLES out of range");
    end
    if (FIFO_DEPTH != 2 && FIFO_DEPTH != 4 && FIFO_DEPTH != 8) begin : g_bad_fd
        $error("FIFO_DEPTH must be 2, 4 or 8");
    end

    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] level_in;

    // Raw idle pattern: pushbuttons idle high, DIP bits idle low.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= IDLE_RAW;
            sync2_q <= IDLE_RAW;
        end else begin
            sync1_q <= {sw3_i, sw2_i, sw1_i};
            sync2_q <= sync1_q;
        end
    end

    assign level_in = sync2_q ^ IDLE_RAW;

    logic [15:0]    cnt_q [NCH];
    logic [NCH-1:0] level_q;
    logic [NCH-1:0] differ;
    logic [NCH-1:0] accept;
    logic [NCH-1:0] queue_req;

    always_comb begin
        differ = level_in ^ level_q;
        accept = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            accept[ch] = differ[ch] && (cnt_q[ch] == CNT_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            level_q <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            level_q <= level_q ^ accept;
            for (int ch = 0; ch < NCH; ch++) begin
                if (!differ[ch] || accept[ch]) begin
                    cnt_q[ch] <= '0;
                end else begin
                    cnt_q[ch] <= cnt_q[ch] + 16'd1;
                end
            end
        end
    end

    assign level_o = level_q;

`ifdef EVENT_RELEASE_EN
    assign queue_req = accept;
`else
    assign queue_req = accept & level_in;
`endif

    logic [NCH-1:0] pend_q;
    logic [NCH-1:0] ptype_q;
    logic [NCH-1:0] grant;
    logic [2:0]     gch;
    logic           wr_en;
    logic           rd_en;
    logic           full;
    logic [7:0]     wr_data;

    // Lowest-numbered pending channel wins; a full FIFO still takes a
    // write when the consumer drains an entry on the same edge.
    always_comb begin
        gch = '0;
        for (int ch = NCH - 1; ch >= 0; ch--) begin
            if (pend_q[ch]) begin
                gch = 3'(ch);
            end
        end
        wr_en = (|pend_q) && (!full || rd_en);
        grant = '0;
        if (wr_en) begin
            grant[gch] = 1'b1;
        end
        wr_data = {ptype_q[gch], 4'b0000, gch};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_q     <= '0;
            ptype_q    <= '0;
            overflow_o <= 1'b0;
        end else begin
            pend_q  <= (pend_q & ~grant) | queue_req;
            ptype_q <= (ptype_q & ~queue_req) | (level_in & queue_req);
            if (|(pend_q & ~grant & queue_req)) begin
                overflow_o <= 1'b1;
            end
        end
    end

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign evt_valid_o = (count_q != '0);
    assign rd_en       = evt_valid_o && evt_ready_i;
    assign evt_o       = evt_valid_o ? mem_q[rd_ptr_q] : 8'h00;

    always_ff @(posedge clk_i) begin
        if (wr_en && !reset_i) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_encoder.sv
// Randomised bench for button_event_encoder against a window/queue model,
// plus directed literal checks on latency, ordering, overflow and reset.
module tb_button_event_encoder;
    localparam int D     = 4;
    localparam int DEPTH = 4;
`ifdef EVENT_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_i;
    logic       sw1_i;
    logic       sw2_i;
    logic [3:0] sw3_i;
    logic [7:0] evt_o;
    logic       evt_valid_o;
    logic       evt_ready_i;
    logic [5:0] level_o;
    logic       overflow_o;

    int checks = 0;
    int errors = 0;

    button_event_encoder #(
        .DEBOUNCE_CYCLES(D),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .sw1_i(sw1_i),
        .sw2_i(sw2_i),
        .sw3_i(sw3_i),
        .evt_o(evt_o),
        .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i),
        .level_o(level_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a level flips once the last D synchronised samples all
    // disagree with it; events queue in a plain array-backed FIFO.
    logic [5:0] m_hist [$];
    logic [7:0] m_q [$];
    logic [5:0] m_lvl;
    logic [5:0] m_pend;
    logic [5:0] m_type;
    logic       m_ovf;
    bit         m_on = 1'b0;

    always @(posedge clk) begin
        int fill;
        bit rd;
        bit flip;
        if (reset_i) begin
            m_hist.delete();
            for (int i = 0; i < D + 2; i++) m_hist.push_back(6'b0);
            m_q.delete();
            m_lvl  = '0;
            m_pend = '0;
            m_type = '0;
            m_ovf  = 1'b0;
            m_on   = 1'b1;
        end else if (m_on) begin
            m_hist.push_back({sw3_i, ~sw2_i, ~sw1_i});
            if (m_hist.size() > D + 2) void'(m_hist.pop_front());
            fill = m_q.size();
            rd = (fill != 0) && evt_ready_i;
            if (rd) void'(m_q.pop_front());
            if (m_pend != 0 && (fill < DEPTH || rd)) begin
                for (int c = 0; c < 6; c++) begin
                    if (m_pend[c]) begin
                        m_q.push_back({m_type[c], 4'b0000, 3'(c)});
                        m_pend[c] = 1'b0;
                        break;
                    end
                end
            end
            for (int c = 0; c < 6; c++) begin
                flip = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (m_hist[j][c] == m_lvl[c]) flip = 1'b0;
                end
                if (flip) begin
                    m_lvl[c] = ~m_lvl[c];
                    if (m_lvl[c] || REL) begin
                        if (m_pend[c]) m_ovf = 1'b1;
                        m_pend[c] = 1'b1;
                        m_type[c] = m_lvl[c];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("valid", {7'b0, evt_valid_o}, {7'b0, m_q.size() != 0});
            if (m_q.size() != 0) chk("evt", evt_o, m_q[0]);
            chk("level", {2'b0, level_o}, {2'b0, m_lvl});
            chk("overflow", {7'b0, overflow_o}, {7'b0, m_ovf});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input logic [5:0] v);
        sw1_i = ~v[0];
        sw2_i = ~v[1];
        sw3_i = v[5:2];
    endtask

    initial begin
        logic [7:0] exp7 [7];
        logic [5:0] tgt;
        int hold [6];
        int rp;
        exp7 = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h80, 8'h84, 8'h85};
        tgt = '0;
        rp = 80;
        for (int c = 0; c < 6; c++) hold[c] = 0;

        reset_i = 1'b1;
        evt_ready_i = 1'b0;
        set_pins(6'b0);
        tick(3);
        reset_i = 1'b0;
        chk("rst_valid", {7'b0, evt_valid_o}, 8'h00);
        chk("rst_evt", evt_o, 8'h00);
        chk("rst_level", {2'b0, level_o}, 8'h00);
        chk("rst_ovf", {7'b0, overflow_o}, 8'h00);

        // sw1 press: level after 2+D clocks, event one clock later
        set_pins(6'b000001);
        tick(5);
        chk("p1_lvl5", {2'b0, level_o}, 8'h00);
        tick(1);
        chk("p1_lvl6", {2'b0, level_o}, 8'h01);
        tick(1);
        chk("p1_valid", {7'b0, evt_valid_o}, 8'h01);
        chk("p1_evt", evt_o, 8'h80);
        evt_ready_i = 1'b1;
        tick(1);
        chk("p1_drained", {7'b0, evt_valid_o}, 8'h00);

        evt_ready_i = 1'b0;
        set_pins(6'b0);
        tick(12);
        chk("rel_valid", {7'b0, evt_valid_o}, {7'b0, REL});
        if (REL) chk("rel_evt", evt_o, 8'h00);
        chk("rel_lvl", {2'b0, level_o}, 8'h00);
        evt_ready_i = 1'b1;
        tick(2);

        // glitch shorter than the debounce window
        set_pins(6'b010000);
        tick(3);
        set_pins(6'b0);
        tick(10);
        chk("glitch_lvl", {2'b0, level_o}, 8'h00);
        chk("glitch_valid", {7'b0, evt_valid_o}, 8'h00);

        // simultaneous presses leave back to back
        set_pins(6'b000110);
        tick(6);
        chk("dual_lvl", {2'b0, level_o}, 8'h06);
        tick(1);
        chk("dual_v1", {7'b0, evt_valid_o}, 8'h01);
        chk("dual_e1", evt_o, 8'h81);
        tick(1);
        chk("dual_v2", {7'b0, evt_valid_o}, 8'h01);
        chk("dual_e2", evt_o, 8'h82);
        tick(1);
        chk("dual_v3", {7'b0, evt_valid_o}, 8'h00);
        set_pins(6'b0);
        tick(12);
        chk("dual_rel", {2'b0, level_o}, 8'h00);

        // seven presses against a stalled consumer
        evt_ready_i = 1'b0;
        set_pins(6'h3F);
        tick(6);
        chk("fill_lvl", {2'b0, level_o}, 8'h3F);
        tick(4);
        chk("fill_valid", {7'b0, evt_valid_o}, 8'h01);
        chk("fill_head", evt_o, 8'h80);
        chk("fill_ovf", {7'b0, overflow_o}, 8'h00);
        set_pins(6'h3E);
        tick(6);
        chk("fill_lvl0", {2'b0, level_o}, 8'h3E);
        set_pins(6'h3F);
        tick(6);
        chk("fill_lvl1", {2'b0, level_o}, 8'h3F);
        chk("fill_ovf7", {7'b0, overflow_o}, {7'b0, REL});
        evt_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("order_v%0d", i), {7'b0, evt_valid_o}, 8'h01);
            chk($sformatf("order_e%0d", i), evt_o, exp7[i]);
            tick(1);
        end
        chk("order_end", {7'b0, evt_valid_o}, 8'h00);

        // pending press re-pressed while FIFO is full -> overflow
        reset_i = 1'b1;
        evt_ready_i = 1'b0;
        set_pins(6'b0);
        tick(1);
        reset_i = 1'b0;
        set_pins(6'b011111);
        tick(11);
        chk("ov_valid", {7'b0, evt_valid_o}, 8'h01);
        chk("ov_head", evt_o, 8'h80);
        chk("ov_pre", {7'b0, overflow_o}, 8'h00);
        set_pins(6'b001111);
        tick(6);
        chk("ov_rel", {7'b0, overflow_o}, {7'b0, REL});
        set_pins(6'b011111);
        tick(6);
        chk("ov_set", {7'b0, overflow_o}, 8'h01);
        tick(5);
        chk("ov_sticky", {7'b0, overflow_o}, 8'h01);

        // reset with a full FIFO, inputs held asserted across release
        reset_i = 1'b1;
        tick(1);
        chk("r2_valid", {7'b0, evt_valid_o}, 8'h00);
        chk("r2_level", {2'b0, level_o}, 8'h00);
        chk("r2_ovf", {7'b0, overflow_o}, 8'h00);
        chk("r2_evt", evt_o, 8'h00);
        reset_i = 1'b0;
        tick(5);
        chk("r2_lvl5", {2'b0, level_o}, 8'h00);
        tick(1);
        chk("r2_lvl6", {2'b0, level_o}, 8'h1F);
        tick(1);
        chk("r2_evv", {7'b0, evt_valid_o}, 8'h01);
        chk("r2_evt1", evt_o, 8'h80);
        evt_ready_i = 1'b1;
        set_pins(6'b0);
        tick(20);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 256 == 0) rp = int'($urandom_range(5, 100));
            for (int c = 0; c < 6; c++) begin
                if (hold[c] == 0) begin
                    tgt[c] = 1'($urandom_range(0, 1));
                    hold[c] = int'($urandom_range(1, 9));
                end else begin
                    hold[c]--;
                end
            end
            set_pins(tgt);
            evt_ready_i = (int'($urandom_range(0, 99)) < rp);
            reset_i = ($urandom_range(0, 699) == 0);
            tick(1);
        end

        reset_i = 1'b0;
        evt_ready_i = 1'b1;
        set_pins(6'b0);
        tick(30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
